// File: rtl/gpio_bank_ctrl.sv
// Register-programmed GPIO bank: per-pin push-pull/open-drain drive, output enable,
// synchronised inputs and rising/falling edge interrupts behind a simple strobe/ack bus.
module gpio_bank_ctrl #(
    parameter int               WIDTH       = 8,
    parameter int               SYNC_STAGES = 2,
    parameter logic [WIDTH-1:0] OD_DEFAULT  = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             bus_stb,
    input  logic             bus_we,
    input  logic [2:0]       bus_addr,
    input  logic [WIDTH-1:0] bus_wdata,
    output logic             bus_ack,
    output logic [WIDTH-1:0] bus_rdata,
    input  logic [WIDTH-1:0] pad_i,
    output logic [WIDTH-1:0] pad_o,
    output logic [WIDTH-1:0] pad_oeb,
    output logic             irq
);

    localparam logic [2:0] ADDR_OUT  = 3'd0;
    localparam logic [2:0] ADDR_OE   = 3'd1;
    localparam logic [2:0] ADDR_OD   = 3'd2;
    localparam logic [2:0] ADDR_IN   = 3'd3;
    localparam logic [2:0] ADDR_RISE = 3'd4;
    localparam logic [2:0] ADDR_FALL = 3'd5;
    localparam logic [2:0] ADDR_STAT = 3'd6;
    localparam logic [2:0] ADDR_TGL  = 3'd7;

    // Warm-up spans the synchroniser fill plus the prev stage so reset-time pad levels never look like edges.
    localparam int                WARM_W    = $clog2(SYNC_STAGES + 2);
    localparam logic [WARM_W-1:0] WARM_LAST = WARM_W'(SYNC_STAGES + 1);

    logic [WIDTH-1:0]  out_r;
    logic [WIDTH-1:0]  oe_r;
    logic [WIDTH-1:0]  od_r;
    logic [WIDTH-1:0]  rise_en_r;
    logic [WIDTH-1:0]  fall_en_r;
    logic [WIDTH-1:0]  irq_stat_r;
    logic [WIDTH-1:0]  sync_r [SYNC_STAGES];
    logic [WIDTH-1:0]  prev_r;
    logic [WARM_W-1:0] warm_r;
    logic              ack_r;
    logic [WIDTH-1:0]  rdata_r;
    logic              irq_r;

    logic              wr_s;
    logic [WIDTH-1:0]  clr_s;
    logic [WIDTH-1:0]  in_s;
    logic [WIDTH-1:0]  rise_s;
    logic [WIDTH-1:0]  fall_s;
    logic [WIDTH-1:0]  rd_mux_s;

    // Write strobe decode and IRQ_STAT write-1-to-clear mask.
    always_comb begin
        wr_s  = bus_stb & bus_we;
        clr_s = '0;
        if (wr_s && (bus_addr == ADDR_STAT)) begin
            clr_s = bus_wdata;
        end else begin
            clr_s = '0;
        end
    end

    // Edge events, gated until the warm-up counter has saturated.
    always_comb begin
        in_s   = sync_r[SYNC_STAGES-1];
        rise_s = '0;
        fall_s = '0;
        if (warm_r == WARM_LAST) begin
            rise_s = in_s & ~prev_r;
            fall_s = ~in_s & prev_r;
        end else begin
            rise_s = '0;
            fall_s = '0;
        end
    end

    // Read data mux.
    always_comb begin
        rd_mux_s = '0;
        case (bus_addr)
            ADDR_OUT:  rd_mux_s = out_r;
            ADDR_OE:   rd_mux_s = oe_r;
            ADDR_OD:   rd_mux_s = od_r;
            ADDR_IN:   rd_mux_s = in_s;
            ADDR_RISE: rd_mux_s = rise_en_r;
            ADDR_FALL: rd_mux_s = fall_en_r;
            ADDR_STAT: rd_mux_s = irq_stat_r;
            ADDR_TGL:  rd_mux_s = '0;
            default:   rd_mux_s = '0;
        endcase
    end

    // Software-programmed control registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_r     <= '0;
            oe_r      <= '0;
            od_r      <= OD_DEFAULT;
            rise_en_r <= '0;
            fall_en_r <= '0;
        end else if (wr_s) begin
            case (bus_addr)
                ADDR_OUT:  out_r     <= bus_wdata;
                ADDR_OE:   oe_r      <= bus_wdata;
                ADDR_OD:   od_r      <= bus_wdata;
                ADDR_RISE: rise_en_r <= bus_wdata;
                ADDR_FALL: fall_en_r <= bus_wdata;
                ADDR_TGL:  out_r     <= out_r ^ bus_wdata;
                default:   out_r     <= out_r;
            endcase
        end
    end

    // Input synchroniser, previous-sample stage and warm-up counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_r[i] <= '0;
            end
            prev_r <= '0;
            warm_r <= '0;
        end else begin
            sync_r[0] <= pad_i;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_r[i] <= sync_r[i-1];
            end
            prev_r <= in_s;
            if (warm_r != WARM_LAST) begin
                warm_r <= warm_r + WARM_W'(1);
            end
        end
    end

    // Interrupt status (set beats a same-cycle clear) and the registered level interrupt.
    always_ff @(posedge clk) begin
        if (rst) begin
            irq_stat_r <= '0;
            irq_r      <= 1'b0;
        end else begin
            irq_stat_r <= (irq_stat_r & ~clr_s) | (rise_s & rise_en_r) | (fall_s & fall_en_r);
            irq_r      <= |irq_stat_r;
        end
    end

    // Bus response: one-cycle ack with read data, zero data on writes.
    always_ff @(posedge clk) begin
        if (rst) begin
            ack_r   <= 1'b0;
            rdata_r <= '0;
        end else begin
            ack_r   <= bus_stb;
            rdata_r <= (bus_stb && !bus_we) ? rd_mux_s : '0;
        end
    end

    // Open-drain pins only ever pull low; push-pull pins follow OUT/OE directly.
    assign pad_o     = out_r & ~od_r;
    assign pad_oeb   = ~(oe_r & ~(od_r & out_r));
    assign bus_ack   = ack_r;
    assign bus_rdata = rdata_r;
    assign irq       = irq_r;

endmodule

// File: tb/tb_gpio_bank_ctrl.sv
// Scoreboard bench for gpio_bank_ctrl (WIDTH=8, SYNC_STAGES=2): bus responses are
// queued at issue and checked by a monitor; pad and irq timing are checked directly.
module tb_gpio_bank_ctrl;

    logic       clk;
    logic       rst;
    logic       bus_stb;
    logic       bus_we;
    logic [2:0] bus_addr;
    logic [7:0] bus_wdata;
    logic       bus_ack;
    logic [7:0] bus_rdata;
    logic [7:0] pad_i;
    logic [7:0] pad_o;
    logic [7:0] pad_oeb;
    logic       irq;

    int         n_chk  = 0;
    int         n_fail = 0;
    logic [7:0] exp_q[$];

    gpio_bank_ctrl #(.WIDTH(8), .SYNC_STAGES(2), .OD_DEFAULT(8'h00)) dut (
        .clk(clk), .rst(rst), .bus_stb(bus_stb), .bus_we(bus_we), .bus_addr(bus_addr),
        .bus_wdata(bus_wdata), .bus_ack(bus_ack), .bus_rdata(bus_rdata),
        .pad_i(pad_i), .pad_o(pad_o), .pad_oeb(pad_oeb), .irq(irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One bus access: strobe for exactly one cycle, expected response queued for the monitor.
    task automatic bus(input logic we, input logic [2:0] addr, input logic [7:0] wdata,
                       input logic [7:0] exp);
        bus_stb   = 1'b1;
        bus_we    = we;
        bus_addr  = addr;
        bus_wdata = wdata;
        exp_q.push_back(exp);
        @(posedge clk);
        #1;
        bus_stb   = 1'b0;
        bus_we    = 1'b0;
        bus_wdata = 8'h00;
    endtask

    task automatic cyc(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Monitor: every ack pops one expected response; idle cycles must show zero read data.
    always @(negedge clk) begin
        if (bus_ack) begin
            n_chk++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL ack_unexpected: got ack with rdata %0h, expected no ack at %0t", bus_rdata, $time);
            end else begin
                logic [7:0] e;
                e = exp_q.pop_front();
                if (bus_rdata !== e) begin
                    n_fail++;
                    $display("FAIL bus_rdata: got %0h expected %0h at %0t", bus_rdata, e, $time);
                end
            end
        end else if (!rst) begin
            n_chk++;
            if (bus_rdata !== 8'h00) begin
                n_fail++;
                $display("FAIL idle_rdata: got %0h expected 0 at %0t", bus_rdata, $time);
            end
        end
    end

    initial begin
        rst       = 1'b1;
        bus_stb   = 1'b0;
        bus_we    = 1'b0;
        bus_addr  = 3'd0;
        bus_wdata = 8'h00;
        pad_i     = 8'hFF;
        cyc(3);
        chk("rst_pad_o", pad_o, 8'h00);
        chk("rst_pad_oeb", pad_oeb, 8'hFF);
        chk("rst_irq", irq, 1'b0);
        chk("rst_ack", bus_ack, 1'b0);
        rst = 1'b0;

        // Pad held high through reset must not raise a rise event.
        bus(1'b1, 3'd4, 8'hFF, 8'h00);
        cyc(6);
        chk("warm_irq", irq, 1'b0);
        bus(1'b0, 3'd6, 8'h00, 8'h00);
        bus(1'b0, 3'd3, 8'h00, 8'hFF);

        // Push-pull drive and toggle.
        bus(1'b1, 3'd1, 8'h0F, 8'h00);
        bus(1'b1, 3'd0, 8'hA5, 8'h00);
        bus(1'b1, 3'd2, 8'h00, 8'h00);
        chk("pp_pad_o", pad_o, 8'hA5);
        chk("pp_pad_oeb", pad_oeb, 8'hF0);
        bus(1'b1, 3'd7, 8'hFF, 8'h00);
        chk("tgl_pad_o", pad_o, 8'h5A);
        bus(1'b0, 3'd0, 8'h00, 8'h5A);
        bus(1'b0, 3'd7, 8'h00, 8'h00);
        bus(1'b1, 3'd3, 8'h00, 8'h00);
        bus(1'b0, 3'd3, 8'h00, 8'hFF);

        // Open-drain: only OUT=0 pins pull low.
        bus(1'b1, 3'd2, 8'hFF, 8'h00);
        bus(1'b1, 3'd1, 8'hFF, 8'h00);
        bus(1'b1, 3'd0, 8'h0F, 8'h00);
        chk("od_pad_o", pad_o, 8'h00);
        chk("od_pad_oeb", pad_oeb, 8'h0F);

        // Rising edge on bit 0: IN at T+2, IRQ_STAT at T+3, irq at T+4.
        bus(1'b1, 3'd4, 8'h01, 8'h00);
        bus(1'b1, 3'd5, 8'h00, 8'h00);
        pad_i = 8'hFE;
        cyc(5);
        bus(1'b0, 3'd6, 8'h00, 8'h00);
        pad_i = 8'hFF;
        cyc(1);
        bus(1'b0, 3'd3, 8'h00, 8'hFE);
        bus(1'b0, 3'd3, 8'h00, 8'hFF);
        chk("rise_irq_t3", irq, 1'b0);
        cyc(1);
        chk("rise_irq_t4", irq, 1'b1);
        bus(1'b0, 3'd6, 8'h00, 8'h01);
        bus(1'b1, 3'd6, 8'h01, 8'h00);
        chk("clr_irq_1", irq, 1'b1);
        cyc(1);
        chk("clr_irq_2", irq, 1'b0);
        bus(1'b0, 3'd6, 8'h00, 8'h00);

        // Falling edge on bit 1 coincides with a W1C of that bit: set wins.
        bus(1'b1, 3'd4, 8'h00, 8'h00);
        bus(1'b1, 3'd5, 8'h02, 8'h00);
        pad_i = 8'hFD;
        cyc(2);
        bus(1'b1, 3'd6, 8'h02, 8'h00);
        bus(1'b0, 3'd6, 8'h00, 8'h02);
        chk("fall_irq", irq, 1'b1);
        bus(1'b1, 3'd5, 8'h00, 8'h00);
        bus(1'b0, 3'd6, 8'h00, 8'h02);
        bus(1'b1, 3'd6, 8'h02, 8'h00);
        bus(1'b0, 3'd6, 8'h00, 8'h00);

        // Back-to-back write then read of OUT.
        bus(1'b1, 3'd0, 8'h3C, 8'h00);
        chk("b2b_ack1", bus_ack, 1'b1);
        bus(1'b0, 3'd0, 8'h00, 8'h3C);
        chk("b2b_ack2", bus_ack, 1'b1);
        chk("b2b_rdata", bus_rdata, 8'h3C);

        // Reset during a strobe drops the ack and restores reset state.
        bus_stb   = 1'b1;
        bus_we    = 1'b1;
        bus_addr  = 3'd1;
        bus_wdata = 8'hFF;
        rst       = 1'b1;
        cyc(1);
        bus_stb   = 1'b0;
        bus_we    = 1'b0;
        chk("mid_rst_ack", bus_ack, 1'b0);
        chk("mid_rst_pad_oeb", pad_oeb, 8'hFF);
        chk("mid_rst_pad_o", pad_o, 8'h00);
        rst = 1'b0;
        bus(1'b0, 3'd1, 8'h00, 8'h00);
        bus(1'b0, 3'd2, 8'h00, 8'h00);

        cyc(3);
        chk("queue_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
